// File: rtl/mandel_frame_buffer_if.sv
// Write-side bus between the Mandelbrot calculator (master) and the frame
// buffer (slave): colour handshake, restart request, progress and done flag.
`timescale 1ns/1ps

interface mandel_frame_buffer_if #(
  parameter int H_ACTIVE = 32,
  parameter int V_ACTIVE = 24,
  parameter int COLOUR_W = 9
);
  logic                        wr_valid;
  logic [COLOUR_W-1:0]         wr_data;
  logic                        wr_ready;
  logic                        restart;
  logic                        frame_done;
  logic [$clog2(H_ACTIVE)-1:0] wr_x;
  logic [$clog2(V_ACTIVE)-1:0] wr_y;

  modport master (
    output wr_valid, wr_data, restart,
    input  wr_ready, frame_done, wr_x, wr_y
  );

  modport slave (
    input  wr_valid, wr_data, restart,
    output wr_ready, frame_done, wr_x, wr_y
  );
endinterface

// File: rtl/mandel_frame_buffer.sv
// Frame store between the Mandelbrot engine and the VGA driver. Clears itself
// after reset, accepts one colour per point in raster order, and scans the
// stored frame out upscaled by SCALE with one cycle of read latency.
`timescale 1ns/1ps

module mandel_frame_buffer #(
  parameter int H_ACTIVE = 32,
  parameter int V_ACTIVE = 24,
  parameter int SCALE    = 20,
  parameter int COLOUR_W = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  mandel_frame_buffer_if.slave wr_bus,
  input  logic                 frame_start,
  input  logic                 scan_active,
  output logic [COLOUR_W-1:0]  pixel_out
);

  localparam int XW    = $clog2(H_ACTIVE);
  localparam int YW    = $clog2(V_ACTIVE);
  localparam int CELLS = H_ACTIVE * V_ACTIVE;
  localparam int AW    = $clog2(CELLS);
  localparam int SW    = $clog2(SCALE);
  localparam int CXW   = $clog2(H_ACTIVE + 1);
  localparam int CYW   = $clog2(V_ACTIVE + 1);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_FILL,
    ST_DONE
  } state_t;

  state_t              r_state;
  logic [XW-1:0]       r_wr_x;
  logic [YW-1:0]       r_wr_y;
  logic                r_frame_done;

  logic [SW-1:0]       r_sub_x;
  logic [SW-1:0]       r_sub_y;
  logic [CXW-1:0]      r_cell_x;
  logic [CYW-1:0]      r_cell_y;
  logic                r_scan_d;
  logic                r_rd_en;
  logic [COLOUR_W-1:0] r_rd_data;
  logic [COLOUR_W-1:0] r_mem [CELLS];

  logic                w_x_wrap;
  logic                w_last_cell;
  logic [XW-1:0]       w_next_x;
  logic [YW-1:0]       w_next_y;
  logic                w_accept;
  logic                w_we;
  logic [COLOUR_W-1:0] w_wdata;
  logic [AW-1:0]       w_wr_addr;

  logic [SW-1:0]       w_sub_x;
  logic [SW-1:0]       w_sub_y;
  logic [CXW-1:0]      w_cell_x;
  logic [CYW-1:0]      w_cell_y;
  logic                w_line_end;
  logic                w_in_range;
  logic [AW-1:0]       w_rd_addr;

  // Write pointer stepping in raster order, shared by the clear sweep and fill
  assign w_x_wrap    = (r_wr_x == XW'(H_ACTIVE - 1));
  assign w_last_cell = w_x_wrap && (r_wr_y == YW'(V_ACTIVE - 1));
  assign w_next_x    = w_x_wrap ? '0 : r_wr_x + 1'b1;
  assign w_next_y    = w_x_wrap ? r_wr_y + 1'b1 : r_wr_y;

  // Handshake is a pure function of state so the calculator never sees a loop
  assign wr_bus.wr_ready   = (r_state == ST_FILL);
  assign wr_bus.frame_done = r_frame_done;
  assign wr_bus.wr_x       = r_wr_x;
  assign wr_bus.wr_y       = r_wr_y;
  assign w_accept          = wr_bus.wr_valid && (r_state == ST_FILL);

  // The clear sweep reuses the single RAM write port, writing zeros
  assign w_we      = (r_state == ST_CLEAR) || w_accept;
  assign w_wdata   = (r_state == ST_CLEAR) ? '0 : wr_bus.wr_data;
  assign w_wr_addr = AW'(r_wr_y) * AW'(H_ACTIVE) + AW'(r_wr_x);

  // Write-side FSM: clear sweep, then fill, then hold until restart
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_CLEAR;
      r_wr_x       <= '0;
      r_wr_y       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (w_last_cell) begin
            r_state <= ST_FILL;
            r_wr_x  <= '0;
            r_wr_y  <= '0;
          end else begin
            r_wr_x <= w_next_x;
            r_wr_y <= w_next_y;
          end
        end
        ST_FILL: begin
          if (wr_bus.restart) begin
            r_wr_x       <= '0;
            r_wr_y       <= '0;
            r_frame_done <= 1'b0;
          end else if (w_accept) begin
            if (w_last_cell) begin
              r_state      <= ST_DONE;
              r_frame_done <= 1'b1;
              r_wr_x       <= '0;
              r_wr_y       <= '0;
            end else begin
              r_wr_x <= w_next_x;
              r_wr_y <= w_next_y;
            end
          end
        end
        ST_DONE: begin
          if (wr_bus.restart) begin
            r_state      <= ST_FILL;
            r_wr_x       <= '0;
            r_wr_y       <= '0;
            r_frame_done <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_wr_x  <= '0;
          r_wr_y  <= '0;
        end
      endcase
    end
  end

  // A frame_start pulse zeroes the scan position before this cycle's pixel
  assign w_sub_x    = frame_start ? '0 : r_sub_x;
  assign w_sub_y    = frame_start ? '0 : r_sub_y;
  assign w_cell_x   = frame_start ? '0 : r_cell_x;
  assign w_cell_y   = frame_start ? '0 : r_cell_y;
  assign w_line_end = r_scan_d && !scan_active && !frame_start;
  assign w_in_range = (w_cell_x < CXW'(H_ACTIVE)) && (w_cell_y < CYW'(V_ACTIVE));
  assign w_rd_addr  = w_in_range ? (AW'(w_cell_y) * AW'(H_ACTIVE) + AW'(w_cell_x)) : '0;

  // Scan counters: SCALE screen pixels per cell, SCALE lines per row, saturating
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sub_x  <= '0;
      r_sub_y  <= '0;
      r_cell_x <= '0;
      r_cell_y <= '0;
      r_scan_d <= 1'b0;
    end else begin
      r_scan_d <= scan_active;
      r_sub_x  <= w_sub_x;
      r_sub_y  <= w_sub_y;
      r_cell_x <= w_cell_x;
      r_cell_y <= w_cell_y;
      if (scan_active) begin
        if (w_sub_x == SW'(SCALE - 1)) begin
          r_sub_x <= '0;
          if (w_cell_x < CXW'(H_ACTIVE)) r_cell_x <= w_cell_x + 1'b1;
        end else begin
          r_sub_x <= w_sub_x + 1'b1;
        end
      end else if (w_line_end) begin
        r_sub_x  <= '0;
        r_cell_x <= '0;
        if (w_sub_y == SW'(SCALE - 1)) begin
          r_sub_y <= '0;
          if (w_cell_y < CYW'(V_ACTIVE)) r_cell_y <= w_cell_y + 1'b1;
        end else begin
          r_sub_y <= w_sub_y + 1'b1;
        end
      end
    end
  end

  // Simple dual-port RAM; the read sees the contents from before this edge's write
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_wr_addr] <= w_wdata;
    r_rd_data <= r_mem[w_rd_addr];
  end

  // Blanking qualifier travels alongside the RAM read so the two stay aligned
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_en <= 1'b0;
    end else begin
      r_rd_en <= scan_active && w_in_range && (r_state != ST_CLEAR);
    end
  end

  assign pixel_out = r_rd_en ? r_rd_data : '0;

endmodule

// File: tb/tb_mandel_frame_buffer.sv
// Directed bench for mandel_frame_buffer: clear sweep, fill, upscaled scan-out,
// handshake throttling, restart behaviour and read/write collision.
`timescale 1ns/1ps

module tb_mandel_frame_buffer;

  localparam int H     = 32;
  localparam int V     = 24;
  localparam int S     = 20;
  localparam int W     = 9;
  localparam int CELLS = H * V;
  localparam int LINE  = H * S;

  logic         clk = 1'b0;
  logic         reset;
  logic         frame_start;
  logic         scan_active;
  logic [W-1:0] pixel_out;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] model [CELLS];
  logic [W-1:0] cap   [LINE];
  int           fb_p;
  logic [W-1:0] fb_act;
  logic [W-1:0] fb_exp;

  mandel_frame_buffer_if #(.H_ACTIVE(H), .V_ACTIVE(V), .COLOUR_W(W)) bus ();

  mandel_frame_buffer #(
    .H_ACTIVE(H), .V_ACTIVE(V), .SCALE(S), .COLOUR_W(W)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .wr_bus     (bus),
    .frame_start(frame_start),
    .scan_active(scan_active),
    .pixel_out  (pixel_out)
  );

  // 100 MHz bench clock; only relative cycle counts matter
  always #5 clk = ~clk;

  // Hard stop in case some loop misbehaves
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout, want $finish before 3 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    scan_active = 1'b0;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic short_lines(input int n);
    for (int k = 0; k < n; k++) begin
      scan_active = 1'b1;
      tick();
      scan_active = 1'b0;
      tick();
    end
  endtask

  // Scan one full active line and count pixels differing from the model row
  task automatic scan_line(input int row, output int errs);
    logic [W-1:0] e_val;
    errs = 0;
    for (int p = 0; p < LINE; p++) begin
      scan_active = 1'b1;
      tick();
      if (row < V) e_val = model[row * H + p / S];
      else         e_val = '0;
      cap[p] = pixel_out;
      if (pixel_out !== e_val) begin
        if (errs == 0) begin fb_p = p; fb_act = pixel_out; fb_exp = e_val; end
        errs++;
      end
    end
    scan_active = 1'b0;
    tick();
    if (pixel_out !== '0) begin
      if (errs == 0) begin fb_p = LINE; fb_act = pixel_out; fb_exp = '0; end
      errs++;
    end
  endtask

  task automatic run_clear(input logic hold_restart, output int cycles,
                           output int pix_bad, output int done_bad);
    cycles   = 0;
    pix_bad  = 0;
    done_bad = 0;
    bus.wr_valid = 1'b1;
    bus.restart  = hold_restart;
    while (cycles < 2000) begin
      scan_active = ((cycles % 4) < 2);
      tick();
      cycles++;
      if (pixel_out !== '0) pix_bad++;
      if (bus.frame_done !== 1'b0) done_bad++;
      if (bus.wr_ready === 1'b1) break;
    end
    bus.wr_valid = 1'b0;
    bus.restart  = 1'b0;
    scan_active  = 1'b0;
  endtask

  task automatic test_reset();
    int c, pb, db;
    reset = 1'b1; frame_start = 1'b0; scan_active = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.restart = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (bus.wr_ready !== 1'b0 || bus.frame_done !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_flags: got ready=%b done=%b, want 0 0", bus.wr_ready, bus.frame_done);
    end
    n_vec++;
    if (bus.wr_x !== 5'd0 || bus.wr_y !== 5'd0 || pixel_out !== 9'd0) begin
      n_err++;
      $display("[TB] FAIL reset_values: got x=%0d y=%0d pix=%0d, want 0 0 0", bus.wr_x, bus.wr_y, pixel_out);
    end
    reset = 1'b0;
    run_clear(1'b0, c, pb, db);
    n_vec++;
    if (c !== 768) begin
      n_err++;
      $display("[TB] FAIL clear_length: got %0d cycles, want 768", c);
    end
    n_vec++;
    if (pb !== 0 || db !== 0) begin
      n_err++;
      $display("[TB] FAIL clear_outputs: got %0d nonzero pixels %0d done cycles, want 0 0", pb, db);
    end
    n_vec++;
    if (bus.wr_x !== 5'd0 || bus.wr_y !== 5'd0) begin
      n_err++;
      $display("[TB] FAIL clear_exit_ptr: got x=%0d y=%0d, want 0 0", bus.wr_x, bus.wr_y);
    end
  endtask

  task automatic test_fill();
    int bad = 0;
    for (int i = 0; i < CELLS; i++) begin
      model[i]     = W'(i % 512);
      bus.wr_valid = 1'b1;
      bus.wr_data  = model[i];
      if (bus.wr_x !== 5'(i % H) || bus.wr_y !== 5'(i / H) ||
          bus.wr_ready !== 1'b1 || bus.frame_done !== 1'b0) bad++;
      tick();
    end
    bus.wr_valid = 1'b0;
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("[TB] FAIL fill_ptr: got %0d bad cycles, want 0", bad);
    end
    n_vec++;
    if (bus.frame_done !== 1'b1 || bus.wr_ready !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL fill_done_rise: got done=%b ready=%b, want 1 0", bus.frame_done, bus.wr_ready);
    end
    n_vec++;
    if (bus.wr_x !== 5'd0 || bus.wr_y !== 5'd0) begin
      n_err++;
      $display("[TB] FAIL fill_done_ptr: got x=%0d y=%0d, want 0 0", bus.wr_x, bus.wr_y);
    end
  endtask

  task automatic test_scan();
    int e;
    start_frame(); scan_line(0, e);
    n_vec++;
    if (e != 0) begin
      n_err++;
      $display("[TB] FAIL scan_line0: pixel %0d got %0d, want %0d", fb_p, fb_act, fb_exp);
    end
    n_vec++;
    if (cap[19] !== 9'd0 || cap[20] !== 9'd1 || cap[639] !== 9'd31) begin
      n_err++;
      $display("[TB] FAIL scan_steps: got %0d %0d %0d, want 0 1 31", cap[19], cap[20], cap[639]);
    end
    start_frame(); short_lines(19); scan_line(0, e);
    n_vec++;
    if (e != 0) begin
      n_err++;
      $display("[TB] FAIL scan_line19: pixel %0d got %0d, want %0d", fb_p, fb_act, fb_exp);
    end
    start_frame(); short_lines(20); scan_line(1, e);
    n_vec++;
    if (e != 0 || cap[0] !== 9'd32) begin
      n_err++;
      $display("[TB] FAIL scan_line20: pixel %0d got %0d, want %0d (first %0d want 32)", fb_p, fb_act, fb_exp, cap[0]);
    end
    start_frame(); short_lines(60); scan_line(3, e);
    n_vec++;
    if (e != 0 || cap[99] !== 9'd100 || cap[100] !== 9'd101 || cap[119] !== 9'd101 || cap[120] !== 9'd102) begin
      n_err++;
      $display("[TB] FAIL cell_5_3: got %0d %0d %0d %0d, want 100 101 101 102", cap[99], cap[100], cap[119], cap[120]);
    end
    start_frame(); short_lines(479); scan_line(23, e);
    n_vec++;
    if (e != 0 || cap[0] !== 9'd224) begin
      n_err++;
      $display("[TB] FAIL scan_last_row: pixel %0d got %0d, want %0d (first %0d want 224)", fb_p, fb_act, fb_exp, cap[0]);
    end
    start_frame(); short_lines(480); scan_line(24, e);
    n_vec++;
    if (e != 0) begin
      n_err++;
      $display("[TB] FAIL scan_out_of_range: pixel %0d got %0d, want 0", fb_p, fb_act);
    end
  endtask

  task automatic test_done_ignore();
    int bad = 0;
    int e;
    for (int k = 0; k < 4; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 9'h1FF;
      tick();
      if (bus.wr_ready !== 1'b0 || bus.frame_done !== 1'b1 ||
          bus.wr_x !== 5'd0 || bus.wr_y !== 5'd0) bad++;
    end
    bus.wr_valid = 1'b0;
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("[TB] FAIL done_hold: got %0d bad cycles, want 0", bad);
    end
    start_frame(); scan_line(0, e);
    n_vec++;
    if (e != 0) begin
      n_err++;
      $display("[TB] FAIL done_no_write: pixel %0d got %0d, want %0d", fb_p, fb_act, fb_exp);
    end
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    n_vec++;
    if (bus.frame_done !== 1'b0 || bus.wr_ready !== 1'b1 || bus.wr_x !== 5'd0 || bus.wr_y !== 5'd0) begin
      n_err++;
      $display("[TB] FAIL restart_done: got done=%b ready=%b x=%0d y=%0d, want 0 1 0 0",
               bus.frame_done, bus.wr_ready, bus.wr_x, bus.wr_y);
    end
  endtask

  task automatic test_random_valid();
    int idx = 0;
    int cyc = 0;
    int bad = 0;
    int tot = 0;
    int e;
    logic v;
    logic [W-1:0] d;
    while (idx < CELLS && cyc < 6000) begin
      v = 1'($urandom_range(0, 1));
      d = W'((idx * 7 + 3) % 512);
      bus.wr_valid = v;
      bus.wr_data  = d;
      if (bus.wr_x !== 5'(idx % H) || bus.wr_y !== 5'(idx / H) || bus.wr_ready !== 1'b1) bad++;
      tick();
      cyc++;
      if (v) begin
        model[idx] = d;
        idx++;
      end
    end
    bus.wr_valid = 1'b0;
    n_vec++;
    if (idx != CELLS) begin
      n_err++;
      $display("[TB] FAIL rand_count: got %0d accepts, want 768", idx);
    end
    n_vec++;
    if (bad != 0 || bus.frame_done !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL rand_ptr: got %0d bad cycles done=%b, want 0 1", bad, bus.frame_done);
    end
    start_frame();
    for (int r = 0; r < V; r++) begin
      scan_line(r, e);
      tot += e;
      short_lines(S - 1);
    end
    n_vec++;
    if (tot != 0) begin
      n_err++;
      $display("[TB] FAIL rand_all_cells: got %0d bad pixels (pixel %0d got %0d want %0d), want 0",
               tot, fb_p, fb_act, fb_exp);
    end
  endtask

  task automatic test_restart_fill();
    int e;
    logic [W-1:0] d;
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    for (int i = 0; i < 74; i++) begin
      d = W'((i + 300) % 512);
      bus.wr_valid = 1'b1;
      bus.wr_data  = d;
      tick();
      model[i] = d;
    end
    n_vec++;
    if (bus.wr_x !== 5'd10 || bus.wr_y !== 5'd2) begin
      n_err++;
      $display("[TB] FAIL restart_pos: got x=%0d y=%0d, want 10 2", bus.wr_x, bus.wr_y);
    end
    bus.wr_valid = 1'b1;
    bus.wr_data  = 9'h0F0;
    bus.restart  = 1'b1;
    tick();
    model[74]    = 9'h0F0;
    bus.wr_valid = 1'b0;
    bus.restart  = 1'b0;
    n_vec++;
    if (bus.wr_x !== 5'd0 || bus.wr_y !== 5'd0 || bus.frame_done !== 1'b0 || bus.wr_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL restart_fill: got x=%0d y=%0d done=%b ready=%b, want 0 0 0 1",
               bus.wr_x, bus.wr_y, bus.frame_done, bus.wr_ready);
    end
    tick();
    n_vec++;
    if (bus.wr_x !== 5'd0 || bus.wr_y !== 5'd0) begin
      n_err++;
      $display("[TB] FAIL restart_idle: got x=%0d y=%0d, want 0 0", bus.wr_x, bus.wr_y);
    end
    start_frame(); short_lines(40); scan_line(2, e);
    n_vec++;
    if (e != 0 || cap[180] !== 9'd373 || cap[200] !== 9'h0F0 || cap[220] !== 9'd16) begin
      n_err++;
      $display("[TB] FAIL restart_contents: got %0d %0d %0d, want 373 240 16", cap[180], cap[200], cap[220]);
    end
  endtask

  task automatic test_reset_mid();
    int c, pb, db, e;
    for (int k = 0; k < 5; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 9'h077;
      tick();
    end
    bus.wr_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++;
    if (bus.wr_x !== 5'd0 || bus.wr_y !== 5'd0 || bus.wr_ready !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_midfill: got x=%0d y=%0d ready=%b, want 0 0 0", bus.wr_x, bus.wr_y, bus.wr_ready);
    end
    repeat (100) tick();
    n_vec++;
    if (bus.wr_x !== 5'd4 || bus.wr_y !== 5'd3 || bus.wr_ready !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL clear_progress: got x=%0d y=%0d ready=%b, want 4 3 0", bus.wr_x, bus.wr_y, bus.wr_ready);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_clear(1'b1, c, pb, db);
    n_vec++;
    if (c !== 768 || pb !== 0 || db !== 0) begin
      n_err++;
      $display("[TB] FAIL reclear_restart: got %0d cycles %0d pix %0d done, want 768 0 0", c, pb, db);
    end
    for (int i = 0; i < CELLS; i++) model[i] = '0;
    start_frame(); scan_line(0, e);
    n_vec++;
    if (e != 0) begin
      n_err++;
      $display("[TB] FAIL reclear_zero: pixel %0d got %0d, want 0", fb_p, fb_act);
    end
  endtask

  task automatic test_collision();
    bus.wr_valid = 1'b1;
    bus.wr_data  = 9'h0AA;
    tick();
    bus.wr_valid = 1'b0;
    bus.restart  = 1'b1;
    tick();
    bus.restart  = 1'b0;
    start_frame();
    short_lines(25);
    scan_active = 1'b1;
    repeat (30) tick();
    frame_start  = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 9'h155;
    tick();
    frame_start  = 1'b0;
    bus.wr_valid = 1'b0;
    n_vec++;
    if (pixel_out !== 9'h0AA) begin
      n_err++;
      $display("[TB] FAIL collision_old: got %0h, want 0aa", pixel_out);
    end
    n_vec++;
    if (bus.wr_x !== 5'd1 || bus.wr_y !== 5'd0) begin
      n_err++;
      $display("[TB] FAIL collision_ptr: got x=%0d y=%0d, want 1 0", bus.wr_x, bus.wr_y);
    end
    tick();
    n_vec++;
    if (pixel_out !== 9'h155) begin
      n_err++;
      $display("[TB] FAIL collision_new: got %0h, want 155", pixel_out);
    end
    scan_active = 1'b0;
    tick();
  endtask

  // Scenario sequence; each task leaves the DUT in the state the next expects
  initial begin
    test_reset();
    test_fill();
    test_scan();
    test_done_ignore();
    test_random_valid();
    test_restart_fill();
    test_reset_mid();
    test_collision();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mandel_frame_buffer.md
# mandel_frame_buffer

Pixel store between the Mandelbrot iteration engine and the VGA driver. Accepts one colour word per completed point from the calculator in raster order through a valid/ready handshake, and holds a full H_ACTIVE×V_ACTIVE frame. It scans the frame out to the VGA driver upscaled by SCALE in both axes, with one cycle of read latency. It owns the post-reset clear sweep and the frame-complete flag that gates the calculator.

## Interface

Parameters:
- H_ACTIVE, 32: stored columns.
- V_ACTIVE, 24: stored rows.
- SCALE, 20: screen pixels per stored cell, each axis.
- COLOUR_W, 9: colour word width ({R[2:0],G[2:0],B[2:0]}).

Ports:
- clk  in  1  pixel clock (25 MHz domain); single clock for the whole block.
- reset  in  1  synchronous, active-high.
- wr_valid  in  1  calculator result valid.
- wr_data  in  COLOUR_W  calculator colour result.
- wr_ready  out  1  buffer accepts a write this cycle.
- restart  in  1  rewind write pointer to (0,0) and clear frame_done; contents kept.
- frame_done  out  1  all H_ACTIVE*V_ACTIVE cells written since last clear/restart.
- wr_x  out  $clog2(H_ACTIVE)  next write column.
- wr_y  out  $clog2(V_ACTIVE)  next write row.
- frame_start  in  1  one-cycle pulse before first active pixel of a screen frame.
- scan_active  in  1  high on each active (visible) screen pixel.
- pixel_out  out  COLOUR_W  registered colour for the screen pixel presented one cycle earlier.

## Operation

- State machine: CLEAR -> FILL -> DONE.
  - CLEAR: entered on reset; writes 0 to one cell per cycle in raster order; H_ACTIVE*V_ACTIVE cycles; wr_ready=0; restart ignored; then FILL with wr_x=wr_y=0.
  - FILL: wr_ready=1; a write is accepted when wr_valid & wr_ready. wr_data goes to cell (wr_x,wr_y). wr_x increments; at H_ACTIVE-1 it wraps to 0 and wr_y increments. Acceptance at (H_ACTIVE-1,V_ACTIVE-1) -> DONE.
  - DONE: wr_ready=0, frame_done=1; wr_valid ignored; restart -> FILL, pointers 0, frame_done 0.
  - restart in FILL: pointers to (0,0) next cycle; a write accepted in the same cycle is stored, then the pointers rewind anyway.
- Read side is independent of write state:
  - Counters sub_x/cell_x and sub_y/cell_y.
  - frame_start clears all four.
  - Each scan_active cycle: sub_x++; at SCALE-1 sub_x->0 and cell_x++.
  - Falling edge of scan_active (end of line): sub_x=cell_x=0, sub_y++; at SCALE-1 sub_y->0 and cell_y++.
  - cell_x>=H_ACTIVE or cell_y>=V_ACTIVE: out of range; pixel_out=0; counters saturate, no wrap.
- pixel_out = scan_active & in-range ? buffer[cell_y][cell_x] : 0, registered. Forced 0 in CLEAR.
- frame_start coincident with scan_active: counters reset first; that pixel reads cell (0,0).
- Same-cycle write and read of one cell: read returns old contents (read-before-write).
- Buffer is inferable synchronous RAM: one write port, one read port; no per-cell reset loop.

## Timing

- Reset values: state=CLEAR, wr_ready=0, frame_done=0, wr_x=wr_y=0, pixel_out=0, read counters 0.
- Reset asserted mid-fill or mid-clear restarts CLEAR from cell 0 on the next edge.
- First FILL cycle is reset deassertion + H_ACTIVE*V_ACTIVE cycles (768 at defaults).
- wr_ready is combinational from state only; it never depends on wr_valid.
- frame_done and DONE are registered; frame_done rises the cycle after the last accepted write.
- Read latency: 1 cycle from scan_active/counter state to pixel_out.
- A cell's new value is visible on pixel_out no earlier than 2 cycles after its write is accepted.

## Test plan

- Reset, then hold wr_valid=1 -> wr_ready stays 0 for exactly 768 cycles. During that window, pixel_out=0 while scan_active toggles.
- FILL with wr_data = raster index mod 512 and wr_valid every cycle -> frame_done rises 1 cycle after the 768th accept and wr_ready falls. Read back via scan: cell (5,3) = 101.
- Scan one line of 640 active pixels after frame_start -> pixel_out changes every 20 cycles, delayed 1 cycle. Row 0 yields cells 0..31 in order; the 20th line still shows row 0 and the 21st shows row 1.
- wr_valid toggling randomly at 50% -> wr_x/wr_y advance only on accepts. No data loss; all 768 cells match the expected values.
- restart mid-FILL at (10,2), then restart in DONE -> pointers return to (0,0) and frame_done clears. Old contents remain visible until overwritten; restart during CLEAR has no effect.
- Write and read of cell (0,0) in the same cycle -> pixel_out shows the old value; the next read shows the new value. frame_start with scan_active high -> that pixel reads cell (0,0).
